// File: rtl/lstm_h_out_pkg.sv
// Shared Q-format constants, data/index typedefs and stage bundles
// for the LSTM hidden-output stage.
package lstm_h_out_pkg;

   localparam int LSTM_D_WL = 16;
   localparam int LSTM_D_FL = 12;
   localparam int LSTM_HID  = 32;
   localparam int LSTM_AW   = 5;

   typedef logic signed [LSTM_D_WL-1:0] data_t;
   typedef logic [LSTM_D_WL-1:0]        word_t;
   typedef logic [LSTM_AW-1:0]          idx_t;

   localparam word_t ONE     = word_t'(1 << LSTM_D_FL);
   localparam word_t HALF    = word_t'(1 << (LSTM_D_FL - 1));
   localparam word_t QUARTER = word_t'(1 << (LSTM_D_FL - 2));
   localparam word_t TWO     = word_t'(1 << (LSTM_D_FL + 1));

   localparam word_t MAX_POS  = word_t'((1 << (LSTM_D_WL - 1)) - 1);
   localparam word_t MOST_NEG = word_t'(1 << (LSTM_D_WL - 1));

   typedef struct packed {
      logic  vld;
      data_t c;
      data_t o;
      idx_t  idx;
   } s1_t;

   typedef struct packed {
      logic  vld;
      data_t t;
      data_t o;
      idx_t  idx;
   } s2_t;

endpackage

// File: rtl/lstm_h_out_tanh_pwl.sv
// Combinational shift-only piecewise-linear tanh in Q.D_FL.
// Works on |x| and restores the sign afterwards.
module tanh_pwl
   import lstm_h_out_pkg::*;
(
   input  data_t x,
   output data_t y
);

   word_t a;
   word_t t;

   always_comb begin
      // Negating the most-negative code would overflow, so clamp it.
      if (word_t'(x) == MOST_NEG) begin
         a = MAX_POS;
      end else if (x[LSTM_D_WL-1]) begin
         a = word_t'(-x);
      end else begin
         a = word_t'(x);
      end

      if (a < HALF) begin
         t = a;
      end else if (a < ONE) begin
         t = (a >> 1) + QUARTER;
      end else if (a < TWO) begin
         t = (a >> 2) + HALF;
      end else begin
         t = ONE;
      end

      y = x[LSTM_D_WL-1] ? data_t'(-t) : data_t'(t);
   end

endmodule

// File: rtl/lstm_h_out.sv
// LSTM hidden output h = o * tanh(c), three-stage pipeline, plus the
// next-timestep cell buffer (built only when LSTM_H_CBUF_EN is defined).
module lstm_h_out
   import lstm_h_out_pkg::*;
#(
   parameter int D_WL = LSTM_D_WL,
   parameter int D_FL = LSTM_D_FL,
   parameter int HID  = LSTM_HID,
   parameter int AW   = LSTM_AW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            c_valid,
   input  logic [D_WL-1:0] c_in,
   input  logic [D_WL-1:0] g_o,
   input  logic            idx_clr,
   input  logic            c_rd_en,
   input  logic [AW-1:0]   c_rd_addr,
   output logic [D_WL-1:0] c_rd_data,
   output logic            h_valid,
   output logic [D_WL-1:0] h_out,
   output logic [AW-1:0]   h_idx,
   output logic            frame_done
);

   idx_t  idx_q, idx_d, idx_cur;
   s1_t   s1_q, s1_d;
   s2_t   s2_q, s2_d;
   logic  h_valid_q, h_valid_d;
   data_t h_q, h_d;
   idx_t  h_idx_q, h_idx_d;
   logic  frame_done_q, frame_done_d;
   data_t t;
   logic [2*D_WL-1:0] prod;

   tanh_pwl u_tanh (
      .x (s1_q.c),
      .y (t)
   );

   always_comb begin
      idx_cur = idx_clr ? '0 : idx_q;
      idx_d   = idx_cur;
      if (c_valid) begin
         idx_d = (idx_cur == idx_t'(HID - 1)) ? '0 : idx_cur + 1'b1;
      end

      s1_d.vld = c_valid;
      s1_d.c   = c_in;
      s1_d.o   = g_o;
      s1_d.idx = idx_cur;

      s2_d.vld = s1_q.vld;
      s2_d.t   = t;
      s2_d.o   = s1_q.o;
      s2_d.idx = s1_q.idx;

      // Sign-extended operands give the exact low 2*D_WL product bits.
      prod = {{D_WL{s2_q.o[D_WL-1]}}, s2_q.o} *
             {{D_WL{s2_q.t[D_WL-1]}}, s2_q.t};

      h_d          = prod[D_FL+D_WL-1:D_FL];
      h_valid_d    = s2_q.vld;
      h_idx_d      = s2_q.idx;
      frame_done_d = s2_q.vld && (s2_q.idx == idx_t'(HID - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q        <= '0;
         s1_q         <= '0;
         s2_q         <= '0;
         h_valid_q    <= 1'b0;
         h_q          <= '0;
         h_idx_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         h_valid_q    <= h_valid_d;
         h_q          <= h_d;
         h_idx_q      <= h_idx_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign h_valid    = h_valid_q;
   assign h_out      = h_q;
   assign h_idx      = h_idx_q;
   assign frame_done = frame_done_q;

`ifdef LSTM_H_CBUF_EN
   data_t cbuf_q [HID];
   data_t cbuf_d [HID];
   data_t rd_q, rd_d;

   always_comb begin
      cbuf_d = cbuf_q;
      if (c_valid) begin
         cbuf_d[idx_cur] = c_in;
      end
      // Reads see cbuf_q, so a same-address write is not yet visible.
      rd_d = c_rd_en ? cbuf_q[c_rd_addr] : rd_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cbuf_q <= '{default: '0};
         rd_q   <= '0;
      end else begin
         cbuf_q <= cbuf_d;
         rd_q   <= rd_d;
      end
   end

   assign c_rd_data = rd_q;
`else
   logic unused_rd;
   assign unused_rd = ^{c_rd_en, c_rd_addr};
   assign c_rd_data = '0;
`endif

endmodule

// File: tb/tb_lstm_h_out.sv
// Randomized scoreboard bench for lstm_h_out; expected h values come
// from an arithmetic tanh/product model, cell-buffer reads from an array.
module tb_lstm_h_out;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c_valid;
   logic [15:0] c_in;
   logic [15:0] g_o;
   logic        idx_clr;
   logic        c_rd_en;
   logic [4:0]  c_rd_addr;
   logic [15:0] c_rd_data;
   logic        h_valid;
   logic [15:0] h_out;
   logic [4:0]  h_idx;
   logic        frame_done;

   lstm_h_out dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .c_valid    (c_valid),
      .c_in       (c_in),
      .g_o        (g_o),
      .idx_clr    (idx_clr),
      .c_rd_en    (c_rd_en),
      .c_rd_addr  (c_rd_addr),
      .c_rd_data  (c_rd_data),
      .h_valid    (h_valid),
      .h_out      (h_out),
      .h_idx      (h_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] h;
      logic [4:0]  idx;
      logic        fd;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          idx_m  = 0;
   logic [15:0] cb [32];
`ifdef LSTM_H_CBUF_EN
   bit          cbuf_en = 1'b1;
`else
   bit          cbuf_en = 1'b0;
`endif

   logic [15:0] edge_c [12] = '{16'h8000, 16'h7FFF, 16'h0800, 16'h07FF,
                                16'h1000, 16'h0FFF, 16'h2000, 16'h1FFF,
                                16'hF800, 16'hF000, 16'hE000, 16'h0000};

   // tanh approximation in real-number terms, scaled by 4096.
   function automatic int tanh_m(int c);
      int a;
      int t;
      a = (c < 0) ? -c : c;
      if (a > 32767) a = 32767;
      if (a < 2048)      t = a;
      else if (a < 4096) t = a / 2 + 1024;
      else if (a < 8192) t = a / 4 + 2048;
      else               t = 4096;
      return (c < 0) ? -t : t;
   endfunction

   function automatic logic [15:0] h_m(logic [15:0] c, logic [15:0] o);
      int os;
      int p;
      os = $signed(o);
      p  = os * tanh_m($signed(c));
      return 16'(p >>> 12);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic step(bit v, logic [15:0] c, logic [15:0] o, bit clr,
                       bit rd, logic [4:0] ra);
      logic [15:0] rexp;
      int          cur;
      exp_t        e;
      c_valid   = v;
      c_in      = c;
      g_o       = o;
      idx_clr   = clr;
      c_rd_en   = rd;
      c_rd_addr = ra;
      rexp = cbuf_en ? cb[ra] : 16'h0000;
      cur  = clr ? 0 : idx_m;
      if (v) begin
         e.h   = h_m(c, o);
         e.idx = 5'(cur);
         e.fd  = (cur == 31);
         sb.push_back(e);
         cb[cur] = c;
         idx_m = (cur + 1) % 32;
      end else begin
         idx_m = cur;
      end
      @(posedge clk);
      #1;
      if (rd) check("rd_data", 32'(c_rd_data), 32'(rexp));
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0, 0, 0, 5'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (h_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_h_valid actual=1 required=0 idx=%0d",
                     h_idx);
         end else begin
            e = sb.pop_front();
            check("h_out", 32'(h_out), 32'(e.h));
            check("h_idx", 32'(h_idx), 32'(e.idx));
            check("frame_done", 32'(frame_done), 32'(e.fd));
         end
      end else if (frame_done) begin
         checks++;
         errors++;
         $display("FAIL lone_frame_done actual=1 required=0");
      end
   end

   initial begin
      logic [15:0] rc;
      for (int i = 0; i < 32; i++) cb[i] = 16'h0;
      rst_n = 1'b0;
      c_valid = 0; c_in = 0; g_o = 0; idx_clr = 0;
      c_rd_en = 0; c_rd_addr = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_h_valid", 32'(h_valid), 0);
      check("rst_h_out", 32'(h_out), 0);
      check("rst_h_idx", 32'(h_idx), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_rd_data", 32'(c_rd_data), 0);
      rst_n = 1'b1;

      for (int a = 0; a < 32; a++) step(0, 16'h0, 16'h0, 0, 1, 5'(a));

      step(1, 16'h0800, 16'h1000, 0, 0, 5'd0);
      step(1, 16'h0400, 16'h1000, 0, 0, 5'd0);
      step(1, 16'h0C00, 16'h1000, 0, 0, 5'd0);
      step(1, 16'h1800, 16'h0800, 0, 0, 5'd0);
      step(1, 16'hE000, 16'h1000, 0, 0, 5'd0);
      step(1, 16'h8000, 16'h1000, 0, 0, 5'd0);
      idle(5);

      for (int k = 0; k < 32; k++)
         step(1, 16'(k * 64), 16'h1000, k == 0, 0, 5'd0);
      step(1, 16'h0123, 16'h0800, 0, 0, 5'd0);
      idle(5);
      for (int k = 0; k < 32; k++) step(0, 16'h0, 16'h0, 0, 1, 5'(k));

      step(1, 16'h1111, 16'h1000, 1, 0, 5'd0);
      step(1, 16'h2222, 16'h1000, 0, 0, 5'd0);
      step(1, 16'h0333, 16'h1000, 0, 0, 5'd0);
      step(1, 16'h3333, 16'h1000, 0, 1, 5'd3);
      step(0, 16'h0, 16'h0, 0, 1, 5'd3);
      idle(5);

      step(1, 16'h0700, 16'h1000, 0, 0, 5'd0);
      step(1, 16'h0900, 16'h1000, 0, 0, 5'd0);
      rst_n = 1'b0;
      c_valid = 1'b0;
      sb.delete();
      idx_m = 0;
      for (int i = 0; i < 32; i++) cb[i] = 16'h0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(6);
      step(1, 16'h0A00, 16'h0C00, 0, 1, 5'd3);
      idle(4);

      for (int n = 0; n < 400; n++) begin
         rc = ($urandom_range(0, 2) == 0) ? edge_c[$urandom_range(0, 11)]
                                          : 16'($urandom);
         step($urandom_range(0, 3) != 0, rc, 16'($urandom),
              $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
              5'($urandom));
      end

      for (int w = 0; w < 20 && sb.size() != 0; w++) idle(1);
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
